sys_ctrl_gen2: RTL

Parametrised second-generation system controller between the UART RX/TX datapath, the register file and the ALU. A single command FSM decodes multi-byte UART frames into register write, register read and ALU operations. Responses (register read data, and ALU results split into BusWidth bytes) are queued in an internal response FIFO. A TX FSM drains the FIFO to the UART transmitter under a busy handshake.

---
 rtl/sys_ctrl_pkg.sv | 33 +++
 rtl/sys_ctrl_resp_fifo.sv | 50 +++++
 rtl/sys_ctrl_gen2.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the second-generation system controller:
// command opcodes, FSM state encodings and operand register addresses.
package sys_ctrl_pkg;

   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int unsigned REG_OPA = 0;
   localparam int unsigned REG_OPB = 1;

   typedef enum logic [3:0] {
      CMD_IDLE,
      CMD_WR_ADDR,
      CMD_WR_DATA,
      CMD_RD_ADDR,
      CMD_RD_WAIT,
      CMD_OP_A,
      CMD_OP_B,
      CMD_FUN,
      CMD_ALU_WAIT,
      CMD_PUSH
   } cmd_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SEND,
      TX_WAIT_BUSY,
      TX_WAIT_DONE
   } tx_state_t;

endpackage

// File: rtl/sys_ctrl_resp_fifo.sv
// Response byte FIFO. Pointers carry one extra wrap bit so that full and
// empty are distinguishable. Writes while full and reads while empty are
// ignored; a simultaneous read and write is fine whenever not full.
module sys_ctrl_resp_fifo #(
   parameter int BusWidth  = 8,
   parameter int RespDepth = 8
) (
   input  logic                clk_sys,
   input  logic                rst_b,
   input  logic                wr_en,
   input  logic [BusWidth-1:0] wr_data,
   input  logic                rd_en,
   output logic [BusWidth-1:0] rd_data,
   output logic                full,
   output logic                empty
);

   localparam int PW = $clog2(RespDepth);

   logic [PW:0]         wr_ptr;
   logic [PW:0]         rd_ptr;
   logic [BusWidth-1:0] mem [RespDepth];

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign rd_data = mem[rd_ptr[PW-1:0]];

   // storage array; contents need no reset since the pointers define validity
   always_ff @(posedge clk_sys) begin
      if (wr_en && !full) begin
         mem[wr_ptr[PW-1:0]] <= wr_data;
      end
   end

   // read/write pointer advance
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sys_ctrl_gen2.sv
// System controller between UART RX/TX, register file and ALU.
// Command FSM decodes UART frames; responses are queued in a byte FIFO and
// drained to the UART transmitter by a TX FSM under a busy handshake.
// Optional build macro SYS_CTRL_RESP_TIMEOUT_EN bounds the response waits
// (RD_WAIT, ALU_WAIT, TX WAIT_BUSY) to TimeoutCycles cycles.
//
// CMD FSM
//   state     | meaning
//   IDLE      | waiting for opcode byte
//   WR_ADDR   | waiting for write address byte
//   WR_DATA   | waiting for write data byte
//   RD_ADDR   | waiting for read address byte
//   RD_WAIT   | waiting for RdData_Valid
//   OP_A      | waiting for operand A byte (written to REG_OPA)
//   OP_B      | waiting for operand B byte (written to REG_OPB)
//   FUN       | waiting for ALU function byte
//   ALU_WAIT  | waiting for ALU_Valid
//   PUSH      | pushing ALU result bytes, LSB first
//
// TX FSM
//   state     | meaning
//   IDLE      | waiting for FIFO data and idle transmitter
//   SEND      | strobe FIFO head to transmitter, pop it
//   WAIT_BUSY | waiting for transmitter to go busy
//   WAIT_DONE | waiting for transmitter to finish
module sys_ctrl_gen2
   import sys_ctrl_pkg::*;
#(
   parameter int BusWidth      = 8,
   parameter int AddWidth      = 4,
   parameter int FuncWidth     = 4,
   parameter int AluOutWidth   = 16,
   parameter int RespDepth     = 8,
   parameter int TimeoutCycles = 255
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [BusWidth-1:0]    RX_P_Data,
   input  logic                   RX_D_VLD,
   input  logic [BusWidth-1:0]    RdData,
   input  logic                   RdData_Valid,
   input  logic [AluOutWidth-1:0] ALU_OUT,
   input  logic                   ALU_Valid,
   input  logic                   TX_Busy,
   output logic                   ALU_EN,
   output logic [FuncWidth-1:0]   ALU_FUN,
   output logic [AddWidth-1:0]    Address,
   output logic                   WrEn,
   output logic                   RdEn,
   output logic [BusWidth-1:0]    WrData,
   output logic [BusWidth-1:0]    TX_P_Data,
   output logic                   TX_D_VLD,
   output logic                   Frame_Err,
   output logic                   Resp_Ovf
);

   localparam int NBytes = AluOutWidth / BusWidth;
   localparam int BCW    = (NBytes > 1) ? $clog2(NBytes) : 1;

   if ((AluOutWidth % BusWidth) != 0) begin : g_chk_alu_width
      $error("AluOutWidth must be a multiple of BusWidth");
   end
   if ((RespDepth < 2) || ((RespDepth & (RespDepth - 1)) != 0) || (RespDepth < NBytes)) begin : g_chk_depth
      $error("RespDepth must be a power of 2, at least 2 and at least AluOutWidth/BusWidth");
   end
   if ((AddWidth > BusWidth) || (FuncWidth > BusWidth)) begin : g_chk_fields
      $error("AddWidth and FuncWidth must not exceed BusWidth");
   end
   if (TimeoutCycles < 1) begin : g_chk_timeout
      $error("TimeoutCycles must be at least 1");
   end

   cmd_state_t cmd_state, cmd_next;
   tx_state_t  tx_state, tx_next;

   logic                   wr_en_d, rd_en_d, alu_en_d, ferr_d;
   logic [AddWidth-1:0]    addr_d;
   logic [BusWidth-1:0]    wdata_d;
   logic [FuncWidth-1:0]   fun_d;
   logic                   push_req;
   logic [BusWidth-1:0]    push_data;
   logic                   alu_ld, alu_shift;
   logic [AluOutWidth-1:0] alu_res;
   logic [BCW-1:0]         byte_cnt;

   logic                   fifo_full, fifo_empty, fifo_pop;
   logic [BusWidth-1:0]    fifo_head;
   logic                   tx_load;

   logic                   cmd_tmo, tx_tmo;

`ifdef SYS_CTRL_RESP_TIMEOUT_EN
   localparam int TW = $clog2(TimeoutCycles + 1);

   logic [TW-1:0] cmd_tmr;
   logic [TW-1:0] tx_tmr;
   logic          cmd_in_wait;

   assign cmd_in_wait = (cmd_state == CMD_RD_WAIT) || (cmd_state == CMD_ALU_WAIT);
   assign cmd_tmo     = cmd_in_wait && (cmd_tmr == '0);
   assign tx_tmo      = (tx_state == TX_WAIT_BUSY) && (tx_tmr == '0);

   // response-wait down-counters: preload outside the wait, count down inside;
   // terminal count is reached on the TimeoutCycles-th cycle of the wait
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cmd_tmr <= TW'(TimeoutCycles - 1);
         tx_tmr  <= TW'(TimeoutCycles - 1);
      end else begin
         if (!cmd_in_wait) begin
            cmd_tmr <= TW'(TimeoutCycles - 1);
         end else if (cmd_tmr != '0) begin
            cmd_tmr <= cmd_tmr - TW'(1);
         end
         if (tx_state != TX_WAIT_BUSY) begin
            tx_tmr <= TW'(TimeoutCycles - 1);
         end else if (tx_tmr != '0) begin
            tx_tmr <= tx_tmr - TW'(1);
         end
      end
   end
`else
   assign cmd_tmo = 1'b0;
   assign tx_tmo  = 1'b0;
`endif

   sys_ctrl_resp_fifo #(
      .BusWidth  (BusWidth),
      .RespDepth (RespDepth)
   ) u_resp_fifo (
      .clk_sys (CLK),
      .rst_b   (RST),
      .wr_en   (push_req),
      .wr_data (push_data),
      .rd_en   (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // command FSM state and registered register-file / ALU strobes
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cmd_state <= CMD_IDLE;
         WrEn      <= 1'b0;
         RdEn      <= 1'b0;
         ALU_EN    <= 1'b0;
         Frame_Err <= 1'b0;
         Address   <= '0;
         WrData    <= '0;
         ALU_FUN   <= '0;
         Resp_Ovf  <= 1'b0;
      end else begin
         cmd_state <= cmd_next;
         WrEn      <= wr_en_d;
         RdEn      <= rd_en_d;
         ALU_EN    <= alu_en_d;
         Frame_Err <= ferr_d;
         Address   <= addr_d;
         WrData    <= wdata_d;
         ALU_FUN   <= fun_d;
         if (push_req && fifo_full) begin
            Resp_Ovf <= 1'b1;
         end
      end
   end

   // ALU result capture and byte serialisation for the PUSH state
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         alu_res  <= '0;
         byte_cnt <= '0;
      end else if (alu_ld) begin
         alu_res  <= ALU_OUT;
         byte_cnt <= '0;
      end else if (alu_shift) begin
         alu_res  <= alu_res >> BusWidth;
         byte_cnt <= byte_cnt + 1'b1;
      end
   end

   // command FSM next-state and strobe decode
   always_comb begin
      cmd_next  = cmd_state;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      alu_en_d  = 1'b0;
      ferr_d    = 1'b0;
      addr_d    = Address;
      wdata_d   = WrData;
      fun_d     = ALU_FUN;
      push_req  = 1'b0;
      push_data = RdData;
      alu_ld    = 1'b0;
      alu_shift = 1'b0;
      case (cmd_state)
         CMD_IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_Data == BusWidth'(CMD_WR)) begin
                  cmd_next = CMD_WR_ADDR;
               end else if (RX_P_Data == BusWidth'(CMD_RD)) begin
                  cmd_next = CMD_RD_ADDR;
               end else if (RX_P_Data == BusWidth'(CMD_ALU_OP)) begin
                  cmd_next = CMD_OP_A;
               end else if (RX_P_Data == BusWidth'(CMD_ALU_NOP)) begin
                  cmd_next = CMD_FUN;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         CMD_WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_d   = RX_P_Data[AddWidth-1:0];
               cmd_next = CMD_WR_DATA;
            end
         end
         CMD_WR_DATA: begin
            if (RX_D_VLD) begin
               wdata_d  = RX_P_Data;
               wr_en_d  = 1'b1;
               cmd_next = CMD_IDLE;
            end
         end
         CMD_RD_ADDR: begin
            if (RX_D_VLD) begin
               addr_d   = RX_P_Data[AddWidth-1:0];
               rd_en_d  = 1'b1;
               cmd_next = CMD_RD_WAIT;
            end
         end
         CMD_RD_WAIT: begin
            if (RdData_Valid) begin
               push_req  = 1'b1;
               push_data = RdData;
               cmd_next  = CMD_IDLE;
            end else if (cmd_tmo) begin
               ferr_d   = 1'b1;
               cmd_next = CMD_IDLE;
            end
         end
         CMD_OP_A: begin
            if (RX_D_VLD) begin
               addr_d   = AddWidth'(REG_OPA);
               wdata_d  = RX_P_Data;
               wr_en_d  = 1'b1;
               cmd_next = CMD_OP_B;
            end
         end
         CMD_OP_B: begin
            if (RX_D_VLD) begin
               addr_d   = AddWidth'(REG_OPB);
               wdata_d  = RX_P_Data;
               wr_en_d  = 1'b1;
               cmd_next = CMD_FUN;
            end
         end
         CMD_FUN: begin
            if (RX_D_VLD) begin
               fun_d    = RX_P_Data[FuncWidth-1:0];
               alu_en_d = 1'b1;
               cmd_next = CMD_ALU_WAIT;
            end
         end
         CMD_ALU_WAIT: begin
            if (ALU_Valid) begin
               alu_ld   = 1'b1;
               cmd_next = CMD_PUSH;
            end else if (cmd_tmo) begin
               ferr_d   = 1'b1;
               cmd_next = CMD_IDLE;
            end
         end
         CMD_PUSH: begin
            push_req  = 1'b1;
            push_data = alu_res[BusWidth-1:0];
            alu_shift = 1'b1;
            if (byte_cnt == BCW'(NBytes - 1)) begin
               cmd_next = CMD_IDLE;
            end
         end
         default: cmd_next = CMD_IDLE;
      endcase
   end

   // TX FSM state and held transmit byte
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tx_state  <= TX_IDLE;
         TX_P_Data <= '0;
      end else begin
         tx_state <= tx_next;
         if (tx_load) begin
            TX_P_Data <= fifo_head;
         end
      end
   end

   assign TX_D_VLD = (tx_state == TX_SEND);

   // TX FSM next-state; the head byte is latched on IDLE->SEND and popped in SEND
   always_comb begin
      tx_next  = tx_state;
      tx_load  = 1'b0;
      fifo_pop = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (!fifo_empty && !TX_Busy) begin
               tx_load = 1'b1;
               tx_next = TX_SEND;
            end
         end
         TX_SEND: begin
            fifo_pop = 1'b1;
            tx_next  = TX_WAIT_BUSY;
         end
         TX_WAIT_BUSY: begin
            if (TX_Busy) begin
               tx_next = TX_WAIT_DONE;
            end else if (tx_tmo) begin
               tx_next = TX_IDLE;
            end
         end
         TX_WAIT_DONE: begin
            if (!TX_Busy) begin
               tx_next = TX_IDLE;
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

endmodule
